// File: rtl/zap_reg_file_pkg.sv
// Physical register map shared across the ZAP core: register count, the dummy
// register that writeback parks unused ports on, and the banked R14/SPSR slots.
package zap_localparams;

   localparam int PHY_REGS         = 46;

   localparam int ARCH_PC          = 15;
   localparam int PHY_PC           = 15;
   localparam int PHY_RAZ_REGISTER = 16;

   localparam int PHY_FIQ_R8       = 17;
   localparam int PHY_FIQ_R9       = 18;
   localparam int PHY_FIQ_R10      = 19;
   localparam int PHY_FIQ_R11      = 20;
   localparam int PHY_FIQ_R12      = 21;
   localparam int PHY_FIQ_R13      = 22;
   localparam int PHY_FIQ_R14      = 23;

   localparam int PHY_IRQ_R13      = 24;
   localparam int PHY_IRQ_R14      = 25;
   localparam int PHY_SVC_R13      = 26;
   localparam int PHY_SVC_R14      = 27;
   localparam int PHY_UND_R13      = 28;
   localparam int PHY_UND_R14      = 29;
   localparam int PHY_ABT_R13      = 30;
   localparam int PHY_ABT_R14      = 31;

   localparam int PHY_FIQ_SPSR     = 32;
   localparam int PHY_IRQ_SPSR     = 33;
   localparam int PHY_SVC_SPSR     = 34;
   localparam int PHY_UND_SPSR     = 35;
   localparam int PHY_ABT_SPSR     = 36;

endpackage

// File: rtl/zap_reg_file.sv
// ZAP physical register file: four combinational read ports, two write ports
// under one shared enable, port B wins on a same-address write collision.
module zap_reg_file
   import zap_localparams::*;
#(
   parameter int PHY_REGS_P = PHY_REGS,
   parameter int AW         = $clog2(PHY_REGS_P)
)(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [AW-1:0] i_wr_addr_a,
   input  logic [AW-1:0] i_wr_addr_b,
   input  logic [31:0]   i_wr_data_a,
   input  logic [31:0]   i_wr_data_b,
   input  logic          i_wen,
   input  logic [AW-1:0] i_rd_addr_a,
   input  logic [AW-1:0] i_rd_addr_b,
   input  logic [AW-1:0] i_rd_addr_c,
   input  logic [AW-1:0] i_rd_addr_d,
   output logic [31:0]   o_rd_data_a,
   output logic [31:0]   o_rd_data_b,
   output logic [31:0]   o_rd_data_c,
   output logic [31:0]   o_rd_data_d
);

   localparam logic [AW:0] NREGS = PHY_REGS_P[AW:0];

   logic [31:0] mem [PHY_REGS_P];

   function automatic logic in_range(input logic [AW-1:0] addr);
      return ({1'b0, addr} < NREGS);
   endfunction

   function automatic logic [31:0] rd(input logic [AW-1:0] addr);
      return in_range(addr) ? mem[addr] : 32'h0;
   endfunction

   // Port B is assigned last so it overrides port A when both hit one address.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < PHY_REGS_P; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (i_wen) begin
         if (in_range(i_wr_addr_a)) mem[i_wr_addr_a] <= i_wr_data_a;
         if (in_range(i_wr_addr_b)) mem[i_wr_addr_b] <= i_wr_data_b;
      end
   end

   always_comb begin
      o_rd_data_a = rd(i_rd_addr_a);
      o_rd_data_b = rd(i_rd_addr_b);
      o_rd_data_c = rd(i_rd_addr_c);
      o_rd_data_d = rd(i_rd_addr_d);
   end

endmodule

// File: tb/tb_zap_reg_file.sv
// Directed bench for zap_reg_file: reset clear, dual write, no-bypass read,
// write enable gating, collision priority, out-of-range drops, reset priority.
module tb_zap_reg_file;

   localparam int AW = 6;
   localparam int NR = 46;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] wr_addr_a, wr_addr_b;
   logic [31:0]   wr_data_a, wr_data_b;
   logic          wen;
   logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
   logic [31:0]   rd_data_a, rd_data_b, rd_data_c, rd_data_d;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_mem [NR];

   zap_reg_file dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_wr_addr_a (wr_addr_a),
      .i_wr_addr_b (wr_addr_b),
      .i_wr_data_a (wr_data_a),
      .i_wr_data_b (wr_data_b),
      .i_wen       (wen),
      .i_rd_addr_a (rd_addr_a),
      .i_rd_addr_b (rd_addr_b),
      .i_rd_addr_c (rd_addr_c),
      .i_rd_addr_d (rd_addr_d),
      .o_rd_data_a (rd_data_a),
      .o_rd_data_b (rd_data_b),
      .o_rd_data_c (rd_data_c),
      .o_rd_data_d (rd_data_d)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd4(input int a, input int b, input int c, input int d);
      rd_addr_a = AW'(a);
      rd_addr_b = AW'(b);
      rd_addr_c = AW'(c);
      rd_addr_d = AW'(d);
      #1;
   endtask

   // One enabled write cycle; the model applies A then B so B wins collisions.
   task automatic do_write(input int aa, input logic [31:0] da, input int ab, input logic [31:0] db);
      wr_addr_a = AW'(aa);
      wr_data_a = da;
      wr_addr_b = AW'(ab);
      wr_data_b = db;
      wen       = 1'b1;
      tick();
      wen       = 1'b0;
      if (aa < NR) exp_mem[aa] = da;
      if (ab < NR) exp_mem[ab] = db;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < NR; i++) begin
         rd4(i, i, i, i);
         check({tag, "_a"}, rd_data_a, exp_mem[i]);
         check({tag, "_d"}, rd_data_d, exp_mem[i]);
      end
   endtask

   initial begin
      reset = 1'b1; wen = 1'b0;
      wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
      rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0; rd_addr_d = '0;
      for (int i = 0; i < NR; i++) exp_mem[i] = 32'h0;
      tick();
      tick();
      reset = 1'b0;

      // Every port reads a different rotation of the address space after reset
      for (int i = 0; i < NR; i++) begin
         rd4(i, NR - 1 - i, (i + 7) % NR, (i + 20) % NR);
         check("rst_a", rd_data_a, 32'h0);
         check("rst_b", rd_data_b, 32'h0);
         check("rst_c", rd_data_c, 32'h0);
         check("rst_d", rd_data_d, 32'h0);
      end

      do_write(3, 32'hDEAD_BEEF, 17, 32'h1234_5678);
      rd4(3, 17, 3, 0);
      check("dual_a", rd_data_a, 32'hDEAD_BEEF);
      check("dual_b", rd_data_b, 32'h1234_5678);
      check("dual_c", rd_data_c, 32'hDEAD_BEEF);
      check("dual_d", rd_data_d, 32'h0);

      // No bypass: the write is only visible after the edge
      do_write(5, 32'h11, 16, 32'h0);
      rd4(5, 5, 5, 5);
      check("old_pre", rd_data_a, 32'h11);
      wr_addr_a = 6'd5; wr_data_a = 32'h22;
      wr_addr_b = 6'd16; wr_data_b = 32'h0;
      wen = 1'b1;
      #1;
      check("nobypass", rd_data_b, 32'h11);
      tick();
      wen = 1'b0;
      exp_mem[5] = 32'h22;
      #1;
      check("after_edge", rd_data_c, 32'h22);

      wr_addr_a = 6'd7; wr_data_a = 32'hFFFF_FFFF;
      wr_addr_b = 6'd7; wr_data_b = 32'hFFFF_FFFF;
      wen = 1'b0;
      tick();
      rd4(7, 7, 7, 7);
      check("wen0", rd_data_a, 32'h0);

      do_write(9, 32'hAAAA_AAAA, 9, 32'hBBBB_BBBB);
      rd4(9, 9, 9, 9);
      check("collide", rd_data_b, 32'hBBBB_BBBB);

      do_write(50, 32'h5555_5555, 16, 32'h0);
      rd4(50, 50, 50, 50);
      check("oob_rd_a", rd_data_a, 32'h0);
      check("oob_rd_c", rd_data_c, 32'h0);
      do_write(10, 32'h0000_0077, 60, 32'h0000_0088);
      rd4(10, 60, 10, 63);
      check("oobB_a", rd_data_a, 32'h0000_0077);
      check("oobB_b", rd_data_b, 32'h0);
      sweep("state");

      // Reset takes priority over a simultaneous write
      reset = 1'b1;
      wr_addr_a = 6'd1; wr_data_a = 32'h0000_0099;
      wr_addr_b = 6'd1; wr_data_b = 32'h0000_0099;
      wen = 1'b1;
      tick();
      reset = 1'b0;
      wen = 1'b0;
      for (int i = 0; i < NR; i++) exp_mem[i] = 32'h0;
      rd4(1, 3, 9, 5);
      check("rstprio_1", rd_data_a, 32'h0);
      check("rstprio_3", rd_data_b, 32'h0);
      check("rstprio_9", rd_data_c, 32'h0);
      check("rstprio_5", rd_data_d, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
